// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: destination-field width helper and index type.
package xbar_pkg;

   localparam int unsigned XBAR_N_OUTPUTS = 2;

   // Destination width is never narrower than one bit, even for a single output.
   function automatic int unsigned xbar_dest_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef logic [xbar_dest_width(XBAR_N_OUTPUTS)-1:0] xbar_dest_t;

endpackage

// File: rtl/xbar_queue_regfile.sv
// Queue storage: one synchronous write port, one combinational read port, no reset.
module xbar_queue_regfile
   import xbar_pkg::*;
#(
   parameter int unsigned BIT_WIDTH = 32,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned AW        = 2
) (
   input  logic                 clk,
   input  logic                 wen,
   input  logic [AW-1:0]        waddr,
   input  logic [BIT_WIDTH-1:0] wdata,
   input  logic [AW-1:0]        raddr,
   output logic [BIT_WIDTH-1:0] rdata
);

   logic [BIT_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wen) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/xbar_input_queue.sv
// Per-input crossbar buffering FIFO with destination decode and illegal-destination drop.
// Optional empty-queue bypass path enabled by defining XBAR_INQ_BYPASS_EN.
module xbar_input_queue
   import xbar_pkg::*;
#(
   parameter int unsigned BIT_WIDTH = 32,
   parameter int unsigned N_OUTPUTS = 2,
   parameter int unsigned DEPTH     = 4
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [BIT_WIDTH-1:0]                  recv_msg,
   input  logic                                  recv_val,
   output logic                                  recv_rdy,
   output logic [BIT_WIDTH-1:0]                  send_msg,
   output logic                                  send_val,
   input  logic                                  send_rdy,
   output logic [xbar_dest_width(N_OUTPUTS)-1:0] send_dest,
   output logic [$clog2(DEPTH+1)-1:0]            count,
   output logic                                  drop
);

   localparam int unsigned DW = xbar_dest_width(N_OUTPUTS);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam logic [AW-1:0] LAST = AW'(DEPTH-1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [BIT_WIDTH-1:0] head_msg;
   logic [DW-1:0]        head_dest;
   logic                 q_val;
   logic                 illegal;
   logic                 head_ok;
   logic                 enq;
   logic                 deq;

   function automatic logic dest_bad(input logic [DW-1:0] d);
      return (32'(d) >= N_OUTPUTS);
   endfunction

   xbar_queue_regfile #(
      .BIT_WIDTH (BIT_WIDTH),
      .DEPTH     (DEPTH),
      .AW        (AW)
   ) u_regfile (
      .clk   (clk),
      .wen   (enq),
      .waddr (wr_ptr),
      .wdata (recv_msg),
      .raddr (rd_ptr),
      .rdata (head_msg)
   );

   assign head_dest = head_msg[BIT_WIDTH-1 -: DW];
   assign q_val     = (count != '0);
   assign illegal   = q_val && dest_bad(head_dest);
   assign head_ok   = q_val && !illegal;
   assign recv_rdy  = (count != FULL);
   assign deq       = (head_ok && send_rdy) || illegal;
   assign drop      = illegal;

`ifdef XBAR_INQ_BYPASS_EN
   logic byp;

   // An empty queue forwards a legal incoming message directly; it is only
   // written into storage if the crossbar does not take it this cycle.
   assign byp       = !q_val && recv_val && !dest_bad(recv_msg[BIT_WIDTH-1 -: DW]);
   assign send_val  = byp || head_ok;
   assign send_msg  = byp ? recv_msg : head_msg;
   assign send_dest = send_msg[BIT_WIDTH-1 -: DW];
   assign enq       = recv_val && recv_rdy && !(byp && send_rdy);
`else
   assign send_val  = head_ok;
   assign send_msg  = head_msg;
   assign send_dest = head_dest;
   assign enq       = recv_val && recv_rdy;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (deq) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_xbar_input_queue.sv
// Scoreboard bench for xbar_input_queue (DEPTH=4, N_OUTPUTS=3, BIT_WIDTH=32).
module tb_xbar_input_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] recv_msg;
   logic        recv_val;
   logic        recv_rdy;
   logic [31:0] send_msg;
   logic        send_val;
   logic        send_rdy;
   logic [1:0]  send_dest;
   logic [2:0]  count;
   logic        drop;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   logic [31:0] drop_q[$];

   xbar_input_queue #(
      .BIT_WIDTH (32),
      .N_OUTPUTS (3),
      .DEPTH     (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .recv_msg  (recv_msg),
      .recv_val  (recv_val),
      .recv_rdy  (recv_rdy),
      .send_msg  (send_msg),
      .send_val  (send_val),
      .send_rdy  (send_rdy),
      .send_dest (send_dest),
      .count     (count),
      .drop      (drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] m, input logic expect_out);
      recv_val = 1'b1;
      recv_msg = m;
      if (expect_out) exp_q.push_back(m);
      step();
   endtask

   // Monitor: consumes one expected message per accepted output or drop.
   always @(negedge clk) begin
      logic [31:0] e;
      if (!reset) begin
         if (send_val && send_rdy) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_send", send_msg, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("send_msg", send_msg, e);
               chk("send_dest", {30'd0, send_dest}, {30'd0, e[31:30]});
            end
         end
         if (drop) begin
            chk("drop_send_val", {31'd0, send_val}, 32'd0);
            if (drop_q.size() == 0) begin
               chk("unexpected_drop", send_msg, 32'hFFFF_FFFF);
            end else begin
               e = drop_q.pop_front();
               chk("drop_msg", send_msg, e);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      recv_val = 1'b0;
      recv_msg = '0;
      send_rdy = 1'b0;
      #12;
      chk("reset_count",    {29'd0, count},    32'd0);
      chk("reset_recv_rdy", {31'd0, recv_rdy}, 32'd1);
      chk("reset_send_val", {31'd0, send_val}, 32'd0);
      chk("reset_drop",     {31'd0, drop},     32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Fill with the crossbar stalled, then drain in order.
`ifndef XBAR_INQ_BYPASS_EN
      recv_val = 1'b1;
      recv_msg = 32'hA0;
      #1 chk("no_comb_path", {31'd0, send_val}, 32'd0);
`endif
      for (int i = 0; i < 4; i++) send(32'hA0 + 32'(i), 1'b1);
      recv_val = 1'b0;
      chk("full_count",    {29'd0, count},    32'd4);
      chk("full_recv_rdy", {31'd0, recv_rdy}, 32'd0);
      send_rdy = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("drain_count", {29'd0, count}, 32'd0);

      // Streaming one-in/one-out wraps both pointers.
      for (int i = 1; i <= 10; i++) begin
         send(32'(i), 1'b1);
`ifdef XBAR_INQ_BYPASS_EN
         chk("stream_count", {29'd0, count}, 32'd0);
`else
         chk("stream_count", {29'd0, count}, 32'd1);
`endif
      end
      recv_val = 1'b0;
      step();
      chk("stream_end_count", {29'd0, count}, 32'd0);

      // Illegal destination 3 is discarded in one cycle.
      send_rdy = 1'b0;
      drop_q.push_back(32'hC000_0001);
      send(32'hC000_0001, 1'b0);
      chk("illegal_drop",     {31'd0, drop},     32'd1);
      chk("illegal_send_val", {31'd0, send_val}, 32'd0);
      send(32'h4000_0002, 1'b1);
      recv_val = 1'b0;
      chk("after_drop_val",  {31'd0, send_val},  32'd1);
      chk("after_drop_msg",  send_msg,           32'h4000_0002);
      chk("after_drop_dest", {30'd0, send_dest}, 32'd1);
      chk("after_drop_bit",  {31'd0, drop},      32'd0);
      send_rdy = 1'b1;
      step();

      // Full queue: a same-cycle dequeue does not open a slot for the new message.
      send_rdy = 1'b0;
      for (int i = 0; i < 4; i++) send(32'hB0 + 32'(i), 1'b1);
      recv_val = 1'b1;
      recv_msg = 32'hBF;
      send_rdy = 1'b1;
      chk("full_deq_recv_rdy", {31'd0, recv_rdy}, 32'd0);
      step();
      recv_val = 1'b0;
      chk("full_deq_count", {29'd0, count}, 32'd3);
      for (int i = 0; i < 3; i++) step();
      chk("full_deq_drained", {29'd0, count}, 32'd0);

      // Asynchronous reset between edges loses queued messages.
      send_rdy = 1'b0;
      for (int i = 0; i < 3; i++) send(32'hD0 + 32'(i), 1'b0);
      recv_val = 1'b0;
      chk("pre_reset_count", {29'd0, count}, 32'd3);
      #2 reset = 1'b1;
      #1;
      chk("async_count",    {29'd0, count},    32'd0);
      chk("async_send_val", {31'd0, send_val}, 32'd0);
      chk("async_recv_rdy", {31'd0, recv_rdy}, 32'd1);
      reset = 1'b0;
      step();
      chk("post_reset_recv_rdy", {31'd0, recv_rdy}, 32'd1);
      send(32'h55, 1'b1);
      recv_val = 1'b0;
      chk("post_reset_val", {31'd0, send_val}, 32'd1);
      chk("post_reset_msg", send_msg, 32'h55);
      chk("post_reset_cnt", {29'd0, count}, 32'd1);
      send_rdy = 1'b1;
      step();

`ifdef XBAR_INQ_BYPASS_EN
      // Empty queue forwards the incoming message in the same cycle.
      exp_q.push_back(32'h77);
      recv_msg = 32'h77;
      recv_val = 1'b1;
      send_rdy = 1'b1;
      #1;
      chk("bypass_val", {31'd0, send_val}, 32'd1);
      chk("bypass_msg", send_msg, 32'h77);
      step();
      recv_val = 1'b0;
      chk("bypass_count", {29'd0, count}, 32'd0);
`endif

      step();
      step();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      chk("drop_q_empty",     32'(drop_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
